// File: rtl/sm_clk_ctrl.sv
// sm_clk_ctrl: board-clock divider for the schoolMIPS core clock.
// Produces a registered 50 % duty clkOut, a coincident one-cycle clkRise
// strobe and a wrapping rise counter. Divide changes land on period
// boundaries, and run/halt drains the current period cleanly.
// Optional single-step support is built when SM_CONFIG_CLK_STEP_EN is defined.
module sm_clk_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DIV_W       = 4,
    parameter int unsigned SHIFT       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clkIn,
    input  logic             rst,
    input  logic [DIV_W-1:0] devide,
    input  logic             enable,
    input  logic             step,
    output logic             clkOut,
    output logic             clkRise,
    output logic             running,
    output logic [DIV_W-1:0] divApplied,
    output logic [31:0]      tickCount
);

    localparam int unsigned TICK_W = 32;

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_STEP  = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] en_sync_q;
    logic [DIV_W-1:0]       dev_sync_q [SYNC_STAGES];
    logic                   en_s_c;
    logic [DIV_W-1:0]       dev_s_c;
    logic                   step_edge_c;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    half_c, top_c;
    logic                counting_c, period_end_c;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                clk_q, clk_d;
    logic                rise_q, rise_d;
    logic                run_q, run_d;
    logic [TICK_W-1:0]   tick_q, tick_d;

    // Enable and divide switch synchronizers
    always_ff @(posedge clkIn) begin
        if (rst) begin
            en_sync_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                dev_sync_q[i] <= '0;
            end
        end else begin
            en_sync_q     <= {en_sync_q[SYNC_STAGES-2:0], enable};
            dev_sync_q[0] <= devide;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                dev_sync_q[i] <= dev_sync_q[i-1];
            end
        end
    end

    assign en_s_c  = en_sync_q[SYNC_STAGES-1];
    assign dev_s_c = dev_sync_q[SYNC_STAGES-1];

`ifdef SM_CONFIG_CLK_STEP_EN
    logic [SYNC_STAGES-1:0] step_sync_q;
    logic                   step_prev_q;

    // Step button synchronizer and rising-edge detector
    always_ff @(posedge clkIn) begin
        if (rst) begin
            step_sync_q <= '0;
            step_prev_q <= 1'b0;
        end else begin
            step_sync_q <= {step_sync_q[SYNC_STAGES-2:0], step};
            step_prev_q <= step_sync_q[SYNC_STAGES-1];
        end
    end

    assign step_edge_c = step_sync_q[SYNC_STAGES-1] & ~step_prev_q;
`else
    logic unused_step;
    assign unused_step = step;
    assign step_edge_c = 1'b0;
`endif

    // State, phase counter and registered outputs
    always_ff @(posedge clkIn) begin
        if (rst) begin
            state_q <= S_HALT;
            cnt_q   <= '0;
            div_q   <= '0;
            clk_q   <= 1'b0;
            rise_q  <= 1'b0;
            run_q   <= 1'b0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            clk_q   <= clk_d;
            rise_q  <= rise_d;
            run_q   <= run_d;
            tick_q  <= tick_d;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        state_d      = state_q;
        half_c       = CNT_W'(1) << (SHIFT + 32'(div_q));
        top_c        = (half_c << 1) - CNT_W'(1);
        counting_c   = (state_q != S_HALT);
        period_end_c = counting_c && (cnt_q == top_c);

        case (state_q)
            S_HALT: begin
                if (en_s_c) begin
                    state_d = S_RUN;
                end else if (step_edge_c) begin
                    state_d = S_STEP;
                end
            end
            S_RUN: begin
                // A period ending as enable drops has nothing left to drain
                if (!en_s_c) begin
                    state_d = period_end_c ? S_HALT : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (period_end_c) begin
                    state_d = en_s_c ? S_RUN : S_HALT;
                end else if (en_s_c) begin
                    state_d = S_RUN;
                end
            end
            S_STEP: begin
                if (period_end_c) begin
                    state_d = en_s_c ? S_RUN : S_HALT;
                end
            end
            default: state_d = S_HALT;
        endcase

        if (!counting_c || period_end_c) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        div_d  = (!counting_c || period_end_c) ? dev_s_c : div_q;
        clk_d  = |(cnt_d & half_c);
        rise_d = counting_c && (cnt_d == half_c);
        run_d  = (state_d != S_HALT);
        tick_d = tick_q + TICK_W'(rise_d);
    end

    assign clkOut     = clk_q;
    assign clkRise    = rise_q;
    assign running    = run_q;
    assign divApplied = div_q;
    assign tickCount  = tick_q;

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// Testbench for sm_clk_ctrl with SHIFT=2: vector table plus step, reset
// and counter-wrap sequences. Step expectations follow SM_CONFIG_CLK_STEP_EN.
module tb_sm_clk_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  devide;
    logic        enable;
    logic        step;
    logic        clkOut;
    logic        clkRise;
    logic        running;
    logic [3:0]  divApplied;
    logic [31:0] tickCount;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sm_clk_ctrl #(
        .CNT_W      (32),
        .DIV_W      (4),
        .SHIFT      (2),
        .SYNC_STAGES(2)
    ) dut (
        .clkIn     (clk),
        .rst       (rst),
        .devide    (devide),
        .enable    (enable),
        .step      (step),
        .clkOut    (clkOut),
        .clkRise   (clkRise),
        .running   (running),
        .divApplied(divApplied),
        .tickCount (tickCount)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic [3:0]  dev;
        int          ncyc;
        logic        clk;
        logic        rise;
        logic        run;
        logic [3:0]  div;
        logic [31:0] tick;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(int r, int e, int d, int n, int c, int ri, int ru, int dv, int t);
        vec_t v;
        v.rst  = 1'(r);
        v.en   = 1'(e);
        v.dev  = 4'(d);
        v.ncyc = n;
        v.clk  = 1'(c);
        v.rise = 1'(ri);
        v.run  = 1'(ru);
        v.div  = 4'(dv);
        v.tick = 32'(t);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises;
        int hi_cycles;
        logic saw_run;
        int exp_rises;
        int exp_hi;
        int exp_run;
        int exp_tick;

        rst    = 1'b1;
        enable = 1'b0;
        devide = 4'd0;
        step   = 1'b0;

        //      rst en dev n   clk rise run div tick
        vq.push_back(mk(1, 0, 0, 2,  0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 0, 2,  0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 0, 1,  0, 0, 1, 0, 0));
        vq.push_back(mk(0, 1, 0, 3,  0, 0, 1, 0, 0));
        vq.push_back(mk(0, 1, 0, 1,  1, 1, 1, 0, 1));
        vq.push_back(mk(0, 1, 0, 1,  1, 0, 1, 0, 1));
        vq.push_back(mk(0, 1, 0, 2,  1, 0, 1, 0, 1));
        vq.push_back(mk(0, 1, 0, 1,  0, 0, 1, 0, 1));
        vq.push_back(mk(0, 1, 0, 4,  1, 1, 1, 0, 2));
        vq.push_back(mk(0, 1, 0, 8,  1, 1, 1, 0, 3));
        // divide change mid-period: current period still 8 cycles
        vq.push_back(mk(0, 1, 1, 3,  1, 0, 1, 0, 3));
        vq.push_back(mk(0, 1, 1, 1,  0, 0, 1, 1, 3));
        vq.push_back(mk(0, 1, 1, 7,  0, 0, 1, 1, 3));
        vq.push_back(mk(0, 1, 1, 1,  1, 1, 1, 1, 4));
        vq.push_back(mk(0, 1, 1, 7,  1, 0, 1, 1, 4));
        vq.push_back(mk(0, 1, 1, 1,  0, 0, 1, 1, 4));
        vq.push_back(mk(0, 1, 0, 8,  1, 1, 1, 1, 5));
        vq.push_back(mk(0, 1, 0, 8,  0, 0, 1, 0, 5));
        vq.push_back(mk(0, 1, 0, 4,  1, 1, 1, 0, 6));
        // drain from high phase into halt
        vq.push_back(mk(0, 0, 0, 3,  1, 0, 1, 0, 6));
        vq.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0, 6));
        vq.push_back(mk(0, 0, 0, 5,  0, 0, 0, 0, 6));
        vq.push_back(mk(0, 1, 0, 3,  0, 0, 1, 0, 6));
        vq.push_back(mk(0, 1, 0, 4,  1, 1, 1, 0, 7));
        // enable glitch: drain resolves to run at period end
        vq.push_back(mk(0, 0, 0, 1,  1, 0, 1, 0, 7));
        vq.push_back(mk(0, 1, 0, 3,  0, 0, 1, 0, 7));
        vq.push_back(mk(0, 1, 0, 4,  1, 1, 1, 0, 8));
        vq.push_back(mk(0, 1, 0, 4,  0, 0, 1, 0, 8));
        // re-enable mid-period during drain: cadence unbroken
        vq.push_back(mk(0, 0, 0, 1,  0, 0, 1, 0, 8));
        vq.push_back(mk(0, 1, 0, 3,  1, 1, 1, 0, 9));
        vq.push_back(mk(0, 1, 0, 8,  1, 1, 1, 0, 10));
        vq.push_back(mk(0, 0, 0, 4,  0, 0, 0, 0, 10));

        @(negedge clk);
        foreach (vq[i]) begin
            rst    = vq[i].rst;
            enable = vq[i].en;
            devide = vq[i].dev;
            cyc(vq[i].ncyc);
            chk($sformatf("row%0d clkOut", i),     32'(clkOut),     32'(vq[i].clk));
            chk($sformatf("row%0d clkRise", i),    32'(clkRise),    32'(vq[i].rise));
            chk($sformatf("row%0d running", i),    32'(running),    32'(vq[i].run));
            chk($sformatf("row%0d divApplied", i), 32'(divApplied), 32'(vq[i].div));
            chk($sformatf("row%0d tickCount", i),  tickCount,       vq[i].tick);
        end

        // single step from halt, with a second press during the step
`ifdef SM_CONFIG_CLK_STEP_EN
        exp_rises = 1;
        exp_hi    = 4;
        exp_run   = 1;
        exp_tick  = 11;
`else
        exp_rises = 0;
        exp_hi    = 0;
        exp_run   = 0;
        exp_tick  = 10;
`endif
        cyc(2);
        rises     = 0;
        hi_cycles = 0;
        saw_run   = 1'b0;
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 4) step = 1'b1;
            if (c == 5) step = 1'b0;
            cyc(1);
            if (clkRise) rises++;
            if (clkOut) hi_cycles++;
            if (running) saw_run = 1'b1;
        end
        chk("step rises",     32'(rises),     32'(exp_rises));
        chk("step high",      32'(hi_cycles), 32'(exp_hi));
        chk("step running",   32'(saw_run),   32'(exp_run));
        chk("step halted",    32'(running),   32'd0);
        chk("step tickCount", tickCount,      32'(exp_tick));

        // reset while cnt=5 at div=1
        devide = 4'd1;
        cyc(3);
        chk("pre-run div", 32'(divApplied), 32'd1);
        enable = 1'b1;
        cyc(8);
        chk("mid running", 32'(running), 32'd1);
        chk("mid clkOut",  32'(clkOut),  32'd0);
        chk("mid div",     32'(divApplied), 32'd1);
        rst    = 1'b1;
        enable = 1'b0;
        cyc(1);
        chk("rst clkOut",    32'(clkOut),     32'd0);
        chk("rst clkRise",   32'(clkRise),    32'd0);
        chk("rst running",   32'(running),    32'd0);
        chk("rst div",       32'(divApplied), 32'd0);
        chk("rst tickCount", tickCount,       32'd0);

        // tick counter wrap
        cyc(1);
        rst    = 1'b0;
        devide = 4'd0;
        enable = 1'b1;
        cyc(2);
        force dut.tick_q = 32'hFFFF_FFFF;
        cyc(1);
        release dut.tick_q;
        chk("wrap preset", tickCount, 32'hFFFF_FFFF);
        cyc(4);
        chk("wrap rise", 32'(clkRise), 32'd1);
        chk("wrap tick", tickCount,    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sm_clk_ctrl.md
# sm_clk_ctrl

Parametrised clock controller that replaces the fixed free-running divider in the schoolMIPS board top. It derives a slow, registered core clock `clkOut` and a matching one-cycle `clkRise` strobe from the board clock. Changes to the divide setting take effect only at period boundaries, so no high or low phase is ever truncated. It supports a run/halt control that drains cleanly and an optional single-step mode for stepping the CPU one clock at a time. Sits between the board switch/button inputs and the CPU/RAM clock nets.

## Interface
Parameters:
- `CNT_W`, 32: width of the phase counter.
- `DIV_W`, 4: width of the divide-exponent input.
- `SHIFT`, 16: base exponent. Half-period is 2^(SHIFT+div) input cycles. Legal only if SHIFT + 2^DIV_W ≤ CNT_W.
- `SYNC_STAGES`, 2: metastability flops on each asynchronous input (minimum 2).

Ports:
- `clkIn`, in, 1: board clock; the only clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `devide`, in, DIV_W: requested divide exponent (async switches).
- `enable`, in, 1: run request (async switch).
- `step`, in, 1: single-step button (async, active-high).
- `clkOut`, out, 1: divided clock, registered.
- `clkRise`, out, 1: one-`clkIn`-cycle pulse, coincident with each `clkOut` 0→1.
- `running`, out, 1: high in every state except HALT.
- `divApplied`, out, DIV_W: divide exponent currently in force.
- `tickCount`, out, 32: number of `clkRise` pulses since reset; wraps.

## Operation
- Each async input passes through SYNC_STAGES flops. All logic uses the synced versions: `devS`, `enS`, `stepS`.
- Phase counter `cnt` spans 0 … 2^(SHIFT+divApplied+1)−1 and increments by 1 when the state is RUN, DRAIN or STEP.
  - At the top value it returns to 0. That event is the **period end**.
  - `clkOut` equals the next value of `cnt[SHIFT+divApplied]`: low for the first half-period, high for the second.
- `divApplied` loads `devS` only at period end, or on any cycle while the state is HALT. A mid-period change to `devide` therefore never alters the current period.
- `clkRise` asserts for the single cycle in which `cnt` becomes 2^(SHIFT+divApplied).
- `tickCount` increments on every `clkRise` and wraps from 2^32−1 to 0.
- State machine (registered):
  - **HALT**: `cnt` is held at 0 and `clkOut` is 0. `enS`=1 → RUN. A rising edge of `stepS` → STEP (macro only).
  - **RUN**: `enS`=0 → DRAIN.
  - **DRAIN**: counts like RUN. `enS`=1 → RUN without any gap. At period end with `enS`=0 → HALT.
  - **STEP**: runs exactly one full period. At period end: `enS`=1 → RUN, otherwise → HALT. `step` edges during STEP, RUN or DRAIN are ignored and are not queued.
- Simultaneous events:
  - Period end and an `enS` change in the same cycle: period end wins, and the transition uses `enS` sampled that cycle.
  - HALT with `enS`=1 and a step edge in the same cycle: RUN wins.
- Reset (any time, including mid-period):
  - State HALT; `cnt`, `clkOut`, `clkRise`, `running` = 0.
  - `divApplied` = 0, `tickCount` = 0.
  - All sync flops and the step-edge flop = 0.

## Timing
- Input pin to synced value: SYNC_STAGES cycles.
- Synced `enS` to state change: 1 further cycle.
- HALT→RUN: the first `cnt` increment occurs on the cycle after the state changes. The first `clkRise` follows 2^(SHIFT+div) cycles later.
- Period: 2^(SHIFT+div+1) `clkIn` cycles, with exactly 50 % duty, for every div in range.
- `clkOut` and `clkRise` are flop outputs. There is no combinational path from any input to any output.

## Configuration
- `SM_CONFIG_CLK_STEP_EN` defined: the STEP state and the `step` synchronizer and edge detector are built.
- Not defined: the `step` port remains but is ignored. STEP is unreachable, and HALT leaves only on `enS`=1.

## Test plan
All scenarios use SHIFT=2, SYNC_STAGES=2 and the macro defined unless stated.
- **Reset, then run:** reset, then `enable`=1, `devide`=0 → `running` rises 3 cycles after `enable`. `clkOut` thereafter has a period of 8 cycles (4 low, 4 high). `clkRise` pulses every 8 cycles; `tickCount` reads 3 after 3 pulses.
- **Divide change mid-period:** while running at div=0, set `devide`=1 in the middle of a period → the current period completes at 8 cycles. `divApplied` becomes 1 at period end; the next period is 16 cycles with no glitch.
- **Drain and resume:** drop `enable` in a high phase → `clkOut` finishes its high phase, then state HALT with `running`=0. Re-raise `enable` during DRAIN → no gap in the 8-cycle cadence.
- **Single step:** in HALT, pulse `step` 1 cycle → exactly one `clkRise` and one 8-cycle period, then HALT. A second pulse during the step → still only one period. With the macro undefined → zero pulses.
- **Mid-operation reset:** assert `rst` while `cnt`=5 → next cycle all outputs 0 and state HALT.
- **Counter wrap:** force `tickCount` to 0xFFFFFFFF, produce one `clkRise` → reads 0.
